toplitz_stream_gen: RTL and testbench

- Upstream im2col stage for conv layers (conv1 by default).
- Reads an input feature map from a single-port input buffer (CHW layout, 1-cycle read latency).
- Streams the Toeplitz matrix row-major into the systolic-array operand feeder, one element per beat, over a valid/ready handshake.
- Inserts zero padding on the fly, with no memory read for padded taps. Output ordering matches the team's toplitz.csv golden layout (M rows x K columns).

---
 rtl/toplitz_stream_gen.sv | 210 +++++++++++++++++++++
 tb/tb_toplitz_stream_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toplitz_stream_gen.sv
// im2col front end: walks the conv window over a CHW input buffer and streams the
// Toeplitz matrix row-major, one element per beat, with zero padding generated on the fly.
module toplitz_stream_gen #(
  parameter int IN_H   = 5,
  parameter int IN_W   = 5,
  parameter int IN_C   = 1,
  parameter int KH     = 3,
  parameter int KW     = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 1,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  localparam int OUT_H = (IN_H + 2*PAD - KH) / STRIDE + 1,
  localparam int OUT_W = (IN_W + 2*PAD - KW) / STRIDE + 1,
  localparam int M     = OUT_H * OUT_W,
  localparam int K     = IN_C * KH * KW,
  localparam int MW    = (M > 1) ? $clog2(M) : 1,
  localparam int KIW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_row_last,
  output logic                     out_frame_last,
  output logic [MW-1:0]            out_m,
  output logic [KIW-1:0]           out_k
);

  localparam int KXW = (KW > 1)    ? $clog2(KW)    : 1;
  localparam int KYW = (KH > 1)    ? $clog2(KH)    : 1;
  localparam int CCW = (IN_C > 1)  ? $clog2(IN_C)  : 1;
  localparam int OXW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OYW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [MW-1:0]            m;
    logic [KIW-1:0]           k;
    logic                     rlast;
    logic                     flast;
  } beat_t;

  state_t r_state, w_state_nxt;

  logic [KXW-1:0] r_kx;
  logic [KYW-1:0] r_ky;
  logic [CCW-1:0] r_c;
  logic [OXW-1:0] r_ox;
  logic [OYW-1:0] r_oy;
  logic [MW-1:0]  r_m;
  logic [KIW-1:0] r_k;
  logic [1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr_hold;

  logic w_kx_wrap, w_ky_wrap, w_c_wrap, w_ox_wrap, w_oy_wrap, w_k_wrap, w_last;
  logic w_issue, w_rd, w_acc, w_pad;
  int   w_iy, w_ix;
  logic [ADDR_W-1:0] w_addr;

  logic           r_vld_p1, r_pad_p1, r_rlast_p1, r_flast_p1;
  logic [MW-1:0]  r_m_p1;
  logic [KIW-1:0] r_k_p1;
  beat_t          w_beat_p1;

  logic  r_vld_p2, r_skd_vld;
  beat_t r_beat_p2, r_skd_beat;

  // Stage 0: coordinate generation and read/pad issue
  assign w_kx_wrap = (r_kx == KXW'(KW - 1));
  assign w_ky_wrap = (r_ky == KYW'(KH - 1));
  assign w_c_wrap  = (r_c  == CCW'(IN_C - 1));
  assign w_ox_wrap = (r_ox == OXW'(OUT_W - 1));
  assign w_oy_wrap = (r_oy == OYW'(OUT_H - 1));
  assign w_k_wrap  = w_kx_wrap && w_ky_wrap && w_c_wrap;
  assign w_last    = w_k_wrap && w_ox_wrap && w_oy_wrap;

  assign w_iy   = int'(r_oy) * STRIDE + int'(r_ky) - PAD;
  assign w_ix   = int'(r_ox) * STRIDE + int'(r_kx) - PAD;
  assign w_pad  = (w_iy < 0) || (w_iy >= IN_H) || (w_ix < 0) || (w_ix >= IN_W);
  assign w_addr = ADDR_W'((int'(r_c) * IN_H + w_iy) * IN_W + w_ix);

  // r_cnt tracks elements issued but not yet accepted; the skid guarantees room for two.
  assign w_acc   = r_vld_p2 && out_ready;
  assign w_issue = (r_state == S_RUN) && ((r_cnt <= 2'd1) || ((r_cnt == 2'd2) && w_acc));
  assign w_rd    = w_issue && !w_pad;

  assign mem_rd_en   = w_rd;
  assign mem_rd_addr = w_rd ? w_addr : r_addr_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_acc && r_beat_p2.flast) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) begin
      r_kx <= '0;
      r_ky <= '0;
      r_c  <= '0;
      r_ox <= '0;
      r_oy <= '0;
      r_m  <= '0;
      r_k  <= '0;
    end else if (w_issue) begin
      r_kx <= w_kx_wrap ? '0 : r_kx + 1'b1;
      if (w_kx_wrap) r_ky <= w_ky_wrap ? '0 : r_ky + 1'b1;
      if (w_kx_wrap && w_ky_wrap) r_c <= w_c_wrap ? '0 : r_c + 1'b1;
      if (w_k_wrap) r_ox <= w_ox_wrap ? '0 : r_ox + 1'b1;
      if (w_k_wrap && w_ox_wrap) r_oy <= w_oy_wrap ? '0 : r_oy + 1'b1;
      r_k <= w_k_wrap ? '0 : r_k + 1'b1;
      if (w_k_wrap) r_m <= w_last ? '0 : r_m + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 2'd0;
      r_addr_hold <= '0;
    end else begin
      unique case ({w_issue, w_acc})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_rd) r_addr_hold <= w_addr;
    end
  end

  // Stage 1: read data returns; padded taps substitute zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
    end
  end

  always_ff @(posedge clk) begin
    r_pad_p1   <= w_pad;
    r_m_p1     <= r_m;
    r_k_p1     <= r_k;
    r_rlast_p1 <= w_k_wrap;
    r_flast_p1 <= w_last;
  end

  assign w_beat_p1 = '{data:  r_pad_p1 ? '0 : mem_rd_data,
                       m:     r_m_p1,
                       k:     r_k_p1,
                       rlast: r_rlast_p1,
                       flast: r_flast_p1};

  // Stage 2: registered output plus one-entry skid for backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_beat_p2 <= '0;
      r_skd_vld <= 1'b0;
    end else if (!r_vld_p2 || w_acc) begin
      if (r_skd_vld) begin
        r_vld_p2  <= 1'b1;
        r_beat_p2 <= r_skd_beat;
        r_skd_vld <= r_vld_p1;
      end else begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) r_beat_p2 <= w_beat_p1;
      end
    end else if (r_vld_p1) begin
      r_skd_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_vld_p1 && (r_skd_vld || (r_vld_p2 && !w_acc))) r_skd_beat <= w_beat_p1;
  end

  assign out_valid      = r_vld_p2;
  assign out_data       = r_beat_p2.data;
  assign out_m          = r_beat_p2.m;
  assign out_k          = r_beat_p2.k;
  assign out_row_last   = r_beat_p2.rlast;
  assign out_frame_last = r_beat_p2.flast;

endmodule

// File: tb/tb_toplitz_stream_gen.sv
// Bench for toplitz_stream_gen: default, STRIDE=2 and IN_C=2 instances checked against
// an index-arithmetic Toeplitz model, with golden rows, random backpressure and resets.
`timescale 1ns/1ps
module tb_toplitz_stream_gen;

  localparam int A_M = 25;
  localparam int A_K = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instance A: default geometry
  logic a_start, a_busy, a_done, a_rd_en, a_vld, a_rdy, a_rl, a_fl;
  logic [15:0] a_rd_addr;
  logic signed [7:0] a_rd_data, a_data;
  logic [4:0] a_m;
  logic [3:0] a_k;
  logic signed [7:0] memA [0:255];
  always @(posedge clk) a_rd_data <= a_rd_en ? memA[a_rd_addr[7:0]] : 8'sh5A;

  // Instance B: STRIDE=2
  logic b_start, b_busy, b_done, b_rd_en, b_vld, b_rdy, b_rl, b_fl;
  logic [15:0] b_rd_addr;
  logic signed [7:0] b_rd_data, b_data;
  logic [3:0] b_m;
  logic [3:0] b_k;
  always @(posedge clk) b_rd_data <= b_rd_en ? 8'(b_rd_addr + 16'd1) : 8'sh5A;

  // Instance C: IN_C=2
  logic c_start, c_busy, c_done, c_rd_en, c_vld, c_rdy, c_rl, c_fl;
  logic [15:0] c_rd_addr;
  logic signed [7:0] c_rd_data, c_data;
  logic [4:0] c_m;
  logic [4:0] c_k;
  always @(posedge clk) c_rd_data <= c_rd_en ? 8'(c_rd_addr + 16'd1) : 8'sh5A;

  toplitz_stream_gen u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
    .out_valid(a_vld), .out_ready(a_rdy), .out_data(a_data),
    .out_row_last(a_rl), .out_frame_last(a_fl), .out_m(a_m), .out_k(a_k));

  toplitz_stream_gen #(.STRIDE(2)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
    .out_valid(b_vld), .out_ready(b_rdy), .out_data(b_data),
    .out_row_last(b_rl), .out_frame_last(b_fl), .out_m(b_m), .out_k(b_k));

  toplitz_stream_gen #(.IN_C(2)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .mem_rd_en(c_rd_en), .mem_rd_addr(c_rd_addr), .mem_rd_data(c_rd_data),
    .out_valid(c_vld), .out_ready(c_rdy), .out_data(c_data),
    .out_row_last(c_rl), .out_frame_last(c_fl), .out_m(c_m), .out_k(c_k));

  int capA [0:511];
  int capB [0:511];
  int capC [0:511];

  // Input address feeding T[m][k] for a 5x5 input, 3x3 kernel; -1 marks a padded tap.
  function automatic int tap(input int s, input int p, input int m, input int k);
    int ow, oy, ox, c, ky, kx, iy, ix;
    ow = (5 + 2*p - 3) / s + 1;
    oy = m / ow;
    ox = m % ow;
    c  = k / 9;
    ky = (k % 9) / 3;
    kx = k % 3;
    iy = oy*s + ky - p;
    ix = ox*s + kx - p;
    if (iy < 0 || iy >= 5 || ix < 0 || ix >= 5) return -1;
    return (c*5 + iy)*5 + ix;
  endfunction

  task automatic run_a(input bit rnd, input int stop_beat, input bit extra_start, input bit after_rst);
    int t = 0, beats = 0, reads = 0, first_rd = -1, first_vld = -1;
    int done_cyc = -1, last_cyc = -1, la = -1;
    int stab_err = 0, busy_err = 0, ost_err = 0, hold_err = 0;
    int rd_addr_q[$];
    int rd_beat_q[$];
    logic signed [7:0] p_data;
    logic [4:0] p_m;
    logic [3:0] p_k;
    logic p_rl, p_fl;
    bit p_stall = 1'b0;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    for (int n = 0; n < A_M*A_K; n++) begin
      int ad;
      ad = tap(1, 1, n / A_K, n % A_K);
      if (ad >= 0) begin
        rd_addr_q.push_back(ad);
        rd_beat_q.push_back(n);
      end
    end
    if (!after_rst) begin
      @(posedge clk);
      #1;
    end
    a_start = 1'b1;
    a_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!fin && t < 3000) begin
      @(negedge clk);
      if (after_rst && t == 0)
        chk("reset_outputs_zero",
            int'(|{a_busy, a_done, a_rd_en, a_vld, a_rl, a_fl, a_data, a_m, a_k, a_rd_addr}), 0);
      if (a_rd_en) begin
        if (first_rd < 0) first_rd = t;
        if (reads < rd_addr_q.size()) begin
          chk($sformatf("rd_addr%0d", reads), int'(a_rd_addr), rd_addr_q[reads]);
          if (rd_beat_q[reads] - (beats + int'(a_vld && a_rdy)) > 1) ost_err++;
        end
        reads++;
        la = int'(a_rd_addr);
      end else if (la >= 0 && int'(a_rd_addr) != la) begin
        hold_err++;
      end
      if ((t == 0 && a_busy) || (t >= 1 && !a_done && !a_busy)) busy_err++;
      if (p_stall && (!a_vld || a_data !== p_data || a_m !== p_m || a_k !== p_k ||
                      a_rl !== p_rl || a_fl !== p_fl)) stab_err++;
      if (a_vld && first_vld < 0) first_vld = t;
      if (a_vld && a_rdy) begin
        int ea, ed, em, ek;
        em = beats / A_K;
        ek = beats % A_K;
        ea = tap(1, 1, em, ek);
        ed = (ea < 0) ? 0 : int'(memA[ea[7:0]]);
        checks++;
        if (int'(a_data) != ed || int'(a_m) != em || int'(a_k) != ek ||
            a_rl != (ek == A_K-1) || a_fl != (beats == A_M*A_K-1)) begin
          failures++;
          $display("FAIL beat%0d: got data=%0d m=%0d k=%0d rl=%0b fl=%0b expected data=%0d m=%0d k=%0d rl=%0b fl=%0b",
                   beats, a_data, a_m, a_k, a_rl, a_fl, ed, em, ek, ek == A_K-1, beats == A_M*A_K-1);
        end
        if (beats < 512) capA[beats] = int'(a_data);
        last_cyc = t;
        beats++;
      end
      p_stall = a_vld && !a_rdy;
      p_data = a_data; p_m = a_m; p_k = a_k; p_rl = a_rl; p_fl = a_fl;
      if (a_done) begin
        done_cyc = t;
        fin = 1'b1;
      end
      if (stop_beat > 0 && beats >= stop_beat) begin
        aborted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      a_start = extra_start && (t == 20 || t == 150);
      a_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    a_start = 1'b0;
    if (!aborted) begin
      chk("a_done_seen", int'(fin), 1);
      chk("a_beats", beats, A_M*A_K);
      chk("a_reads", reads, rd_addr_q.size());
      chk("a_stable_when_stalled", stab_err, 0);
      chk("a_outstanding_le2", ost_err, 0);
      chk("a_busy_window", busy_err, 0);
      chk("a_addr_hold", hold_err, 0);
      if (!rnd) begin
        chk("a_first_read_cycle", first_rd, 1 + rd_beat_q[0]);
        chk("a_first_valid_cycle", first_vld, 3);
        chk("a_last_beat_cycle", last_cyc, 2 + A_M*A_K);
        chk("a_done_cycle", done_cyc, 3 + A_M*A_K);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("a_done_one_cycle", int'(a_done), 0);
      chk("a_idle_after_done", int'(a_busy), 0);
    end
  endtask

  task automatic run_bc(input bit sel);
    int mm = sel ? 25 : 9;
    int kk = sel ? 18 : 9;
    int s  = sel ? 1 : 2;
    int t = 0, beats = 0, reads = 0, done_cyc = -1, exp_reads = 0;
    bit fin = 1'b0;
    string nm = sel ? "c" : "b";
    for (int n = 0; n < mm*kk; n++) if (tap(s, 1, n / kk, n % kk) >= 0) exp_reads++;
    @(posedge clk);
    #1;
    b_start = !sel;
    c_start = sel;
    while (!fin && t < 3000) begin
      @(negedge clk);
      if (sel ? c_rd_en : b_rd_en) reads++;
      if (sel ? c_vld : b_vld) begin
        int ea, ed, em, ek, gd, gm, gk;
        logic grl, gfl;
        em = beats / kk;
        ek = beats % kk;
        ea = tap(s, 1, em, ek);
        ed = (ea < 0) ? 0 : ea + 1;
        gd = sel ? int'(c_data) : int'(b_data);
        gm = sel ? int'(c_m) : int'(b_m);
        gk = sel ? int'(c_k) : int'(b_k);
        grl = sel ? c_rl : b_rl;
        gfl = sel ? c_fl : b_fl;
        checks++;
        if (gd != ed || gm != em || gk != ek || grl != (ek == kk-1) || gfl != (beats == mm*kk-1)) begin
          failures++;
          $display("FAIL %s_beat%0d: got data=%0d m=%0d k=%0d rl=%0b fl=%0b expected data=%0d m=%0d k=%0d",
                   nm, beats, gd, gm, gk, grl, gfl, ed, em, ek);
        end
        if (beats < 512) begin
          if (sel) capC[beats] = gd;
          else     capB[beats] = gd;
        end
        beats++;
      end
      if (sel ? c_done : b_done) begin
        done_cyc = t;
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
      b_start = 1'b0;
      c_start = 1'b0;
    end
    chk({nm, "_beats"}, beats, mm*kk);
    chk({nm, "_reads"}, reads, exp_reads);
    chk({nm, "_done_cycle"}, done_cyc, 3 + mm*kk);
  endtask

  typedef struct packed {
    logic [1:0]      cfg;
    logic [7:0]      m;
    logic [7:0]      koff;
    logic [0:8][7:0] v;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = {2'd0, 8'd0,  8'd0, 8'd0,  8'd0,  8'd0, 8'd0,  8'd1,  8'd2,  8'd0,  8'd6,  8'd7};
    tbl[1] = {2'd0, 8'd12, 8'd0, 8'd7,  8'd8,  8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
    tbl[2] = {2'd0, 8'd24, 8'd0, 8'd19, 8'd20, 8'd0, 8'd24, 8'd25, 8'd0,  8'd0,  8'd0,  8'd0};
    tbl[3] = {2'd1, 8'd4,  8'd0, 8'd7,  8'd8,  8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
    tbl[4] = {2'd2, 8'd0,  8'd9, 8'd0,  8'd0,  8'd0, 8'd0,  8'd26, 8'd27, 8'd0,  8'd31, 8'd32};

    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
    for (int i = 0; i < 256; i++) memA[i] = 8'(i + 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_a(1'b0, 0, 1'b0, 1'b0);
    run_bc(1'b0);
    run_bc(1'b1);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 9; j++) begin
        int got;
        case (tbl[i].cfg)
          2'd0:    got = capA[int'(tbl[i].m)*9 + int'(tbl[i].koff) + j];
          2'd1:    got = capB[int'(tbl[i].m)*9 + int'(tbl[i].koff) + j];
          default: got = capC[int'(tbl[i].m)*18 + int'(tbl[i].koff) + j];
        endcase
        chk($sformatf("row_cfg%0d_m%0d_k%0d", tbl[i].cfg, tbl[i].m, int'(tbl[i].koff) + j),
            got, int'(tbl[i].v[j]));
      end
    end

    for (int i = 0; i < 256; i++) memA[i] = 8'($urandom);
    run_a(1'b1, 0, 1'b0, 1'b0);
    run_a(1'b1, 0, 1'b1, 1'b0);

    for (int i = 0; i < 256; i++) memA[i] = 8'(i + 1);
    run_a(1'b0, 50, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_a(1'b0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
